// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } lsu_state_t;

  localparam int unsigned LSU_TIMEOUT = 255;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Clear/enable cycle counter that flags the last cycle a bus access may take.
module lsu_timeout_ctr
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Holds at the terminal count so it can never wrap while the FSM leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tc = (cnt_q == TermCnt);

endmodule

// File: rtl/load_store_unit.sv
// Word-only data-memory access unit: req/gnt/rvalid bus handshake with core stall,
// misalignment detection and timeout abort.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = LSU_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  input  logic                  dbus_gnt,
  input  logic                  dbus_rvalid,
  input  logic [DATA_WIDTH-1:0] dbus_rdata
);

  lsu_state_t            state_q;
  logic                  done_q;
  logic                  misalign_q;
  logic                  bus_err_q;
  logic                  dbus_req_q;
  logic                  dbus_we_q;
  logic [ADDR_WIDTH-1:0] dbus_addr_q;
  logic [DATA_WIDTH-1:0] dbus_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic req;
  logic aligned;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  assign req     = mem_write | mem_read;
  assign aligned = (addr[1:0] == 2'b00);
  assign cnt_clr = (state_q == StIdle) && req && aligned;
  assign cnt_en  = (state_q == StReq) || (state_q == StResp);

  lsu_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_wdata_q <= '0;
      rdata_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            // rdata only carries a word after a successful load.
            rdata_q <= '0;
            if (!aligned) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q      <= StReq;
              dbus_req_q   <= 1'b1;
              dbus_we_q    <= mem_write;
              dbus_addr_q  <= addr;
              dbus_wdata_q <= wdata;
            end
          end
        end
        StReq: begin
          if (cnt_tc) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            bus_err_q  <= 1'b1;
            dbus_req_q <= 1'b0;
          end else if (dbus_gnt) begin
            dbus_req_q <= 1'b0;
            if (dbus_we_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StResp;
            end
          end
        end
        StResp: begin
          if (cnt_tc) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
          end else if (dbus_rvalid) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            rdata_q <= dbus_rdata;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Combinational from IDLE so the issuing instruction is frozen in its own cycle.
  assign stall = ((state_q == StIdle) && req) || (state_q == StReq) || (state_q == StResp);

  assign done       = done_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;
  assign rdata      = rdata_q;
  assign dbus_req   = dbus_req_q;
  assign dbus_we    = dbus_we_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_wdata = dbus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// checked against a cycle-count model derived from the access rules.
module tb_load_store_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_write;
  logic          mem_read;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          stall;
  logic [DW-1:0] rdata;
  logic          done;
  logic          misalign;
  logic          bus_err;
  logic          dbus_req;
  logic          dbus_we;
  logic [AW-1:0] dbus_addr;
  logic [DW-1:0] dbus_wdata;
  logic          dbus_gnt;
  logic          dbus_rvalid;
  logic [DW-1:0] dbus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .done       (done),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_wdata (dbus_wdata),
    .dbus_gnt   (dbus_gnt),
    .dbus_rvalid(dbus_rvalid),
    .dbus_rdata (dbus_rdata)
  );

  task automatic drive_idle();
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    addr        = '0;
    wdata       = '0;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata  = '0;
  endtask

  // One instruction's access. gw = REQ cycles without gnt, rw = RESP cycles without rvalid.
  task automatic run_access(input string name, input logic we, input logic rd,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input int gw, input int rw, input logic [DW-1:0] rv);
    bit            mis;
    bit            tmo;
    int            bus_n;
    int            req_cyc;
    int            bus_cyc;
    int            total;
    bit            in_req;
    bit            in_resp;
    bit            rv_now;
    logic [DW-1:0] exp_rd;
    logic [4:0]    got_v;
    logic [4:0]    exp_v;
    mis     = (a[1:0] != 2'b00);
    bus_n   = we ? gw + 1 : gw + rw + 2;
    tmo     = !mis && (bus_n >= int'(TO));
    req_cyc = mis ? 0 : ((gw + 1 < int'(TO)) ? gw + 1 : int'(TO));
    bus_cyc = mis ? 0 : (tmo ? int'(TO) : bus_n);
    total   = bus_cyc + 2;
    exp_rd  = (!mis && !tmo && !we) ? rv : '0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      mem_write   = we;
      mem_read    = rd;
      addr        = a;
      wdata       = wd;
      in_req      = (c >= 2) && (c <= 1 + req_cyc);
      in_resp     = !we && (c >= 2 + req_cyc) && (c <= 1 + bus_cyc);
      rv_now      = !we && !mis && !tmo && (c == gw + 3 + rw);
      dbus_gnt    = (!mis && (gw + 1 < int'(TO)) && (c == gw + 2)) ||
                    (in_resp && ($urandom_range(0, 1) == 1));
      dbus_rvalid = rv_now || (in_req && ($urandom_range(0, 1) == 1));
      dbus_rdata  = rv_now ? rv : $urandom();
      #1;
      got_v = {stall, done, dbus_req, misalign, bus_err};
      exp_v = {c < total, c == total, in_req, mis && (c == total), tmo && (c == total)};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s ctl cycle %0d: {stall,done,req,misalign,bus_err} got %b expected %b",
                 name, c, got_v, exp_v);
      end
      if (in_req) begin
        n_checks++;
        if ({dbus_we, dbus_addr, dbus_wdata} !== {we, a, wd}) begin
          n_fail++;
          $display("FAIL %s bus cycle %0d: we/addr/wdata got %b/%h/%h expected %b/%h/%h",
                   name, c, dbus_we, dbus_addr, dbus_wdata, we, a, wd);
        end
      end
      if (c == total) begin
        n_checks++;
        if (rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL %s rdata: got %h expected %h", name, rdata, exp_rd);
        end
      end
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      drive_idle();
      #1;
      n_checks++;
      if ({stall, done, dbus_req, misalign, bus_err} !== 5'b0) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: {stall,done,req,misalign,bus_err} got %b expected 00000",
                 name, c, {stall, done, dbus_req, misalign, bus_err});
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({stall, done, misalign, bus_err, dbus_req, dbus_we, rdata, dbus_addr, dbus_wdata} !== '0)
    begin
      n_fail++;
      $display("FAIL %s: outputs not zero: stall=%b done=%b mis=%b err=%b req=%b we=%b rdata=%h addr=%h wdata=%h",
               name, stall, done, misalign, bus_err, dbus_req, dbus_we, rdata, dbus_addr,
               dbus_wdata);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_quiet("after_reset", 2);
  endtask

  task automatic test_store();
    run_access("store", 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, '0);
    check_quiet("store_tail", 1);
  endtask

  task automatic test_load_waits();
    run_access("load_waits", 1'b0, 1'b1, 32'h200, 32'h0, 3, 1, 32'h12345678);
    check_quiet("load_tail", 1);
  endtask

  task automatic test_misalign();
    run_access("misalign", 1'b0, 1'b1, 32'h102, 32'h0, 0, 0, 32'hFFFF_FFFF);
    check_quiet("misalign_tail", 1);
  endtask

  task automatic test_timeout();
    run_access("timeout", 1'b0, 1'b1, 32'h300, 32'h0, 100, 0, '0);
    @(negedge clk);
    drive_idle();
    dbus_gnt = 1'b1;
    #1;
    n_checks++;
    if ({stall, done, dbus_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_gnt: {stall,done,req} got %b expected 000", {stall, done, dbus_req});
    end
    check_quiet("timeout_tail", 2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_read = 1'b1;
    addr     = 32'h0000_0440;
    wdata    = 32'hA5A5_A5A5;
    @(negedge clk);
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    #1;
    n_checks++;
    if ({stall, dbus_addr} !== {1'b1, 32'h0000_0440}) begin
      n_fail++;
      $display("FAIL reset_mid_setup: stall/addr got %b/%h expected 1/00000440", stall, dbus_addr);
    end
    #1;
    drive_idle();
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dbus_rvalid = 1'b1;
    dbus_rdata  = 32'hBAD0_BAD0;
    #1;
    n_checks++;
    if ({stall, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_rvalid: {stall,done} got %b expected 00", {stall, done});
    end
    check_quiet("reset_mid_tail", 2);
    run_access("post_reset_store", 1'b1, 1'b0, 32'h0000_0500, 32'h0BAD_F00D, 1, 0, '0);
    check_quiet("post_reset_tail", 1);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_load", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 0, 0, 32'hCAFE_0001);
    run_access("b2b_both", 1'b1, 1'b1, 32'h0000_0020, 32'h1357_9BDF, 0, 0, '0);
    check_quiet("b2b_tail", 1);
  endtask

  task automatic test_random();
    logic          we;
    logic          rd;
    logic [AW-1:0] a;
    int            gw;
    int            rw;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      rd = we ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      gw = $urandom_range(0, 3);
      rw = $urandom_range(0, 2);
      run_access("random", we, rd, a, $urandom(), gw, rw, $urandom());
      if ($urandom_range(0, 1) == 1) check_quiet("random_gap", 1);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_waits();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit downstream of the control unit. It takes the decoded memory controls (`mem_write`, load select) together with the ALU-computed address and store data, and runs a request/grant/response transaction on the data bus. While the access is in flight it stalls the core. It returns load data to the writeback result mux. Word accesses only, matching the `lw`/`sw` decode.

## Interface
- `ADDR_WIDTH`, 32: data bus address width.
- `DATA_WIDTH`, 32: data word width.
- `TIMEOUT`, 255: maximum cycles spent in REQ+RESP before aborting. Must be ≥ 2.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_write`  in  1  store request from the control unit.
- `mem_read`  in  1  load request; driven by the control unit's `result_src`.
- `addr`  in  ADDR_WIDTH  ALU result, byte address.
- `wdata`  in  DATA_WIDTH  store data (rs2).
- `stall`  out  1  freezes PC and register-file write.
- `rdata`  out  DATA_WIDTH  load result, valid while `done` = 1.
- `done`  out  1  access completes this cycle; core advances at this edge.
- `misalign`  out  1  1-cycle pulse, `addr[1:0]` ≠ 0; no bus access made.
- `bus_err`  out  1  1-cycle pulse, timeout abort.
- `dbus_req`  out  1  bus request, held until grant.
- `dbus_we`  out  1  1 = write.
- `dbus_addr`  out  ADDR_WIDTH  registered address.
- `dbus_wdata`  out  DATA_WIDTH  registered store data.
- `dbus_gnt`  in  1  request accepted.
- `dbus_rvalid`  in  1  read data valid.
- `dbus_rdata`  in  DATA_WIDTH  read data.

## Operation
- States: IDLE, REQ, RESP, DONE.
- **IDLE**
  - `req` = `mem_write` | `mem_read`.
  - If `req` and `addr[1:0]` ≠ 0: go to DONE with `misalign` flagged.
  - Else if `req`: latch `addr`, `wdata`, `we` = `mem_write` into the `dbus_*` registers; go to REQ.
  - Write has priority if both inputs are high.
- **REQ**
  - `dbus_req` = 1.
  - On `dbus_gnt`: a write goes to DONE; a read goes to RESP.
- **RESP**
  - On `dbus_rvalid`: capture `dbus_rdata` into the rdata register; go to DONE.
  - `dbus_rvalid` is sampled only in RESP. In any other state it is ignored.
- **DONE**
  - `done` = 1 and `stall` = 0.
  - Next state is unconditionally IDLE.
  - `misalign` and `bus_err` pulse here when flagged.
- **Stall rule:** `stall` = (IDLE & `req`) | REQ | RESP. This is combinational from IDLE so the issuing cycle is frozen.
- **Timeout:** the counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches `TIMEOUT`−1, the next state is DONE with `bus_err` flagged.
  - `dbus_req` drops on that transition.
  - Any late `gnt`/`rvalid` is ignored.
- **rdata:** the captured word on a successful load. It is 0 after a store, misalign, or timeout.

## Timing
- **Reset values:** state IDLE; `stall` 0, `done` 0, `misalign` 0, `bus_err` 0, `rdata` 0, `dbus_req` 0, `dbus_we` 0, `dbus_addr` 0, `dbus_wdata` 0, timeout counter 0.
- **Zero-wait store:** 3 cycles for the instruction (IDLE, REQ with gnt, DONE); stall is high for 2 cycles.
- **Zero-wait load:** 4 cycles (IDLE, REQ, RESP with rvalid, DONE).
- **Misaligned access:** 2 cycles (IDLE, DONE).
- **Back-to-back accesses:** an access in the instruction after DONE starts in the following IDLE cycle. There is no idle gap beyond that cycle.
- **Reset mid-transaction:** all outputs, including `dbus_req`, go low asynchronously. Any response arriving after reset is ignored.
- **Bus protocol:** `dbus_*` outputs are stable from REQ entry until DONE.

## Structure
- Package `lsu_pkg`: `lsu_state_t` enum (IDLE, REQ, RESP, DONE) and the default `LSU_TIMEOUT` constant.
- Sub-module `lsu_timeout_ctr`: clear/enable counter with a terminal-count output, `$clog2(TIMEOUT)` bits wide.
- The FSM and datapath registers stay in `load_store_unit`.

## Test plan
- **Store, immediate gnt:** `mem_write` = 1, `addr` = 0x100, `wdata` = 0xDEADBEEF.
  - `dbus_req`/`dbus_we`/`dbus_addr`/`dbus_wdata` are valid in cycle 2.
  - `done` is high in cycle 3.
  - `stall` pattern is 1, 1, 0.
- **Load, gnt after 3 waits, rvalid after 2 more:** `dbus_rdata` = 0x12345678.
  - `rdata` = 0x12345678 while `done` = 1.
  - `stall` is high for 7 cycles.
- **Misaligned load:** `addr` = 0x102.
  - `dbus_req` never asserts.
  - `misalign` and `done` pulse in cycle 2; `rdata` = 0.
- **Timeout, no gnt, `TIMEOUT` = 8:**
  - `dbus_req` is high for 8 cycles.
  - `bus_err` and `done` pulse; a later `dbus_gnt` is ignored and the state stays IDLE.
- **Reset during RESP:**
  - All outputs are 0 immediately.
  - A later `dbus_rvalid` produces no `done`.
  - A fresh store then completes normally.
- **Back-to-back load then store:**
  - Second REQ starts 1 cycle after the first DONE.
  - `mem_write` and `mem_read` both high gives a write transaction.
